// File: rtl/gate_truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// gate_truth_table_sequencer
//
// Self-test controller for a 2-input combinational gate. A start request
// walks the gate inputs {x,y} through vectors 00, 01, 10, 11. Each vector is
// held for SETTLE cycles, after which the gate output z is sampled and
// compared against TRUTH_TABLE[vector]. The result is reported as a pass
// flag, a mismatch count and a per-vector failure map.
//
// Parameters
//   TRUTH_TABLE  expected z for each vector; bit i is for {x,y} == i
//   SETTLE       cycles each vector is held before z is sampled (1..15)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   run request, only looked at while idle
//   abort      in   abandons a run in progress (no done pulse)
//   z          in   output of the gate under test
//   x, y       out  gate inputs, {x,y} = current vector index
//   busy       out  high while vectors are being applied
//   done       out  one-cycle pulse after a completed run
//   pass       out  last completed run had no mismatches
//   err_count  out  number of mismatching vectors (0..4)
//   fail_vec   out  bit i set when vector i mismatched
// ---------------------------------------------------------------------------
module gate_truth_table_sequencer #(
    parameter logic [3:0] TRUTH_TABLE = 4'b1110,
    parameter int         SETTLE      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       z,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter reload: the sample edge is the one where the counter is zero,
    // so loading SETTLE-1 gives exactly SETTLE cycles per vector.
    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

    state_t     state_reg;
    logic [1:0] idx_reg;
    logic [3:0] cnt_reg;

    logic       mismatch;
    logic [1:0] idx_next;
    logic [2:0] err_count_next;
    logic [3:0] fail_vec_next;
    logic [3:0] idx_onehot;

    // Result bookkeeping for the current sample edge. These values are only
    // committed on a sample edge in RUN; elsewhere they are ignored.
    always_comb begin
        mismatch       = z ^ TRUTH_TABLE[idx_reg];
        idx_next       = idx_reg + 2'd1;
        idx_onehot     = 4'b0001 << idx_reg;
        fail_vec_next  = fail_vec | (mismatch ? idx_onehot : 4'b0000);
        err_count_next = err_count + {2'b00, mismatch};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 2'd0;
            cnt_reg   <= 4'd0;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    x    <= 1'b0;
                    y    <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        state_reg <= ST_RUN;
                        busy      <= 1'b1;
                        idx_reg   <= 2'd0;
                        cnt_reg   <= CNT_RELOAD;
                        // Results of the previous run are dropped only when
                        // a new run is actually accepted.
                        err_count <= 3'd0;
                        fail_vec  <= 4'd0;
                        pass      <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        // Partial err_count/fail_vec are kept for diagnosis;
                        // pass is still 0 from the start of this run.
                        state_reg <= ST_IDLE;
                        x         <= 1'b0;
                        y         <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        fail_vec  <= fail_vec_next;
                        err_count <= err_count_next;
                        if (idx_reg != 2'd3) begin
                            idx_reg <= idx_next;
                            x       <= idx_next[1];
                            y       <= idx_next[0];
                            cnt_reg <= CNT_RELOAD;
                        end else begin
                            state_reg <= ST_DONE;
                            x         <= 1'b0;
                            y         <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            // Verdict includes the vector sampled right now.
                            pass      <= (err_count_next == 3'd0);
                        end
                    end
                end

                ST_DONE: begin
                    // Single-cycle state; start is deliberately not sampled
                    // here, so a held start restarts from IDLE one cycle on.
                    state_reg <= ST_IDLE;
                    done      <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    x         <= 1'b0;
                    y         <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
module tb_gate_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Main instance: default OR table, SETTLE = 2
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       z;
    logic       x, y, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    int         mode = 0; // 0 OR, 1 AND, 2 stuck0, 3 stuck1

    // Second instance: AND table, SETTLE = 1
    logic       start2 = 1'b0;
    logic       z2;
    logic       x2, y2, busy2, done2, pass2;
    logic [2:0] err_count2;
    logic [3:0] fail_vec2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            1:       z = x & y;
            2:       z = 1'b0;
            3:       z = 1'b1;
            default: z = x | y;
        endcase
    end
    assign z2 = x2 & y2;

    gate_truth_table_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .z(z),
        .x(x), .y(y), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    gate_truth_table_sequencer #(.TRUTH_TABLE(4'b1000), .SETTLE(1)) u_dut_and (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .z(z2),
        .x(x2), .y(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .fail_vec(fail_vec2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic [2:0] e_err,
                                 input logic [3:0] e_fv, input logic e_pass);
        check({tag, "_err"},  {5'd0, err_count}, {5'd0, e_err});
        check({tag, "_fv"},   {4'd0, fail_vec},  {4'd0, e_fv});
        check({tag, "_pass"}, {7'd0, pass},      {7'd0, e_pass});
    endtask

    // Full SETTLE=2 run on the main instance. start_mask bit c drives start
    // into edge E(c) while the run is in progress (should be ignored).
    task automatic run_check(input string tag, input logic [7:0] start_mask,
                             input logic [2:0] e_err, input logic [3:0] e_fv,
                             input logic e_pass);
        logic [1:0] vec;
        start = 1'b1;
        @(negedge clk);           // after E0
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vec = 2'(c / 2);
            check({tag, "_xy"},   {6'd0, x, y},     {6'd0, vec});
            check({tag, "_busy"}, {7'd0, busy},     8'd1);
            check({tag, "_done0"}, {7'd0, done},    8'd0);
            start = (c < 7) ? start_mask[c + 1] : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;             // now after E8
        check({tag, "_done"},   {7'd0, done}, 8'd1);
        check({tag, "_busyE8"}, {7'd0, busy}, 8'd0);
        check({tag, "_xyE8"},   {6'd0, x, y}, 8'd0);
        check_results(tag, e_err, e_fv, e_pass);
        $display("run %s: err=%0d fv=%b pass=%0d", tag, err_count, fail_vec, pass);
        @(negedge clk);           // after E9
        check({tag, "_doneoff"}, {7'd0, done}, 8'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_xy", {6'd0, x, y}, 8'd0);
        check_results("rst", 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct OR
        mode = 0;
        run_check("or_ok", 8'h00, 3'd0, 4'b0000, 1'b1);

        // AND gate against OR table
        mode = 1;
        run_check("and_wrong", 8'h00, 3'd2, 4'b0110, 1'b0);

        // z stuck at 0
        mode = 2;
        run_check("stuck0", 8'h00, 3'd3, 4'b1110, 1'b0);

        // AND table, SETTLE=1 instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("s1_xy", {6'd0, x2, y2}, 8'(c));
            check("s1_busy", {7'd0, busy2}, 8'd1);
            @(negedge clk);
        end
        check("s1_done", {7'd0, done2}, 8'd1);
        check("s1_pass", {7'd0, pass2}, 8'd1);
        check("s1_err", {5'd0, err_count2}, 8'd0);
        check("s1_fv", {4'd0, fail_vec2}, 8'd0);
        $display("run s1_and: err=%0d fv=%b pass=%0d", err_count2, fail_vec2, pass2);
        @(negedge clk);
        check("s1_doneoff", {7'd0, done2}, 8'd0);

        // Abort at E3 with z stuck 1
        mode = 3;
        start = 1'b1;
        @(negedge clk);           // after E0
        start = 1'b0;
        @(negedge clk);           // after E1
        @(negedge clk);           // after E2
        check("ab_xyE2", {6'd0, x, y}, 8'd1);
        abort = 1'b1;
        @(negedge clk);           // after E3
        abort = 1'b0;
        check("ab_busy", {7'd0, busy}, 8'd0);
        check("ab_xy", {6'd0, x, y}, 8'd0);
        check_results("ab", 3'd1, 4'b0001, 1'b0);
        for (int c = 0; c < 8; c++) begin
            check("ab_nodone", {7'd0, done}, 8'd0);
            @(negedge clk);
        end
        $display("run abort: err=%0d fv=%b pass=%0d", err_count, fail_vec, pass);
        mode = 0;
        run_check("after_abort", 8'h00, 3'd0, 4'b0000, 1'b1);

        // Start pulses at E2 and E5 during a run are ignored
        run_check("start_ign", 8'b0010_0100, 3'd0, 4'b0000, 1'b1);

        // Start held high: back-to-back runs
        start = 1'b1;
        @(negedge clk);           // after E0
        for (int c = 0; c < 8; c++) @(negedge clk);
        check("held_done", {7'd0, done}, 8'd1);
        check("held_busyE8", {7'd0, busy}, 8'd0);
        @(negedge clk);           // after E9 (DONE -> IDLE)
        check("held_busyE9", {7'd0, busy}, 8'd0);
        check("held_doneE9", {7'd0, done}, 8'd0);
        @(negedge clk);           // after E10: restarted
        start = 1'b0;
        check("held_restart", {7'd0, busy}, 8'd1);
        check("held_xy", {6'd0, x, y}, 8'd0);
        for (int c = 0; c < 8; c++) @(negedge clk);
        check("held_done2", {7'd0, done}, 8'd1);
        check_results("held2", 3'd0, 4'd0, 1'b1);
        $display("run held: err=%0d fv=%b pass=%0d", err_count, fail_vec, pass);
        @(negedge clk);

        // Asynchronous reset mid-run
        mode = 2;
        start = 1'b1;
        @(negedge clk);           // after E0
        start = 1'b0;
        repeat (4) @(negedge clk); // after E4: vector 1 failed
        check("rr_err_pre", {5'd0, err_count}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_busy", {7'd0, busy}, 8'd0);
        check("rr_xy", {6'd0, x, y}, 8'd0);
        check("rr_done", {7'd0, done}, 8'd0);
        check_results("rr", 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 0;
        run_check("post_rst", 8'h00, 3'd0, 4'b0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total simulation time
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gate_truth_table_sequencer.md
# gate_truth_table_sequencer

Self-test controller for a 2-input combinational logic gate (OR by default, any 2-input function by parameter). On a start request it drives the gate inputs through all four input vectors, waits a programmable settle time, samples the gate output, and compares it against the expected truth table. It reports a pass/fail verdict, a mismatch count and a per-vector failure map. It sits between the lab control logic (or a bench) and the gate under test, and owns the gate's inputs while a run is in progress.

## Interface
Parameters:
- `TRUTH_TABLE`, default `4'b1110`: expected output; bit i is the expected `z` for input vector i = {x,y} (OR).
- `SETTLE`, default `2`: cycles each vector is held before `z` is sampled; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `abort`  in  1  synchronous abort of a run in progress.
- `z`  in  1  output of the gate under test.
- `x`  out  1  gate input, = vector index bit 1.
- `y`  out  1  gate input, = vector index bit 0.
- `busy`  out  1  high while vectors are being applied.
- `done`  out  1  one-cycle pulse at the end of a completed run.
- `pass`  out  1  high when the last completed run had 0 mismatches.
- `err_count`  out  3  number of mismatching vectors, 0..4.
- `fail_vec`  out  4  bit i set if vector i mismatched.

## Operation
- States: IDLE, RUN, DONE. Internal registers: 2-bit vector index `idx` and a 4-bit settle counter `cnt`.
- **IDLE:**
  - `x`=`y`=0, `busy`=0.
  - When `start`=1 at an edge, the block enters RUN and sets `busy`<=1, `idx`<=0, {x,y}<=00, `cnt`<=SETTLE-1.
  - At the same edge it clears `err_count`, `fail_vec` and `pass`.
- **RUN, edge with `cnt`!=0:** `cnt` decrements; `x` and `y` hold.
- **RUN, edge with `cnt`==0 (sample edge):**
  - The block compares `z` against `TRUTH_TABLE[idx]`.
  - On mismatch it sets `fail_vec[idx]` and increments `err_count`.
  - If `idx`<3: `idx` increments, {x,y}<=new idx, `cnt`<=SETTLE-1.
  - If `idx`==3: the block enters DONE, {x,y}<=00, `busy`<=0, `done`<=1, and `pass` is set to (final mismatch count == 0).
- **DONE:** lasts exactly one cycle. The block then returns to IDLE with `done`<=0. `start` is ignored in DONE.
- **`abort`** (any RUN edge, priority over sampling): the block goes to IDLE with {x,y}<=00 and `busy`<=0. There is no `done` pulse and `pass` stays 0. `err_count` and `fail_vec` retain their partial values, and no compare is made at that edge. `abort` has no effect in IDLE or DONE.
- `start` while `busy`=1 is ignored. If `start` is held high continuously, a new run begins on the first IDLE edge after DONE.
- `pass`, `err_count` and `fail_vec` hold their values until the next accepted `start`.

## Timing
- Reset (async, immediate): state=IDLE, `x`=`y`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `idx`=0, `cnt`=0. Reset mid-run discards the run.
- Let E0 be the edge that accepts `start`. Vector k (k=0..3) is driven from E0+k·SETTLE. `z` for vector k is sampled at edge E0+(k+1)·SETTLE.
- `busy` is high for 4·SETTLE cycles (E0 to E0+4·SETTLE). `done` is high for the one cycle after E0+4·SETTLE.
- Result outputs are valid in the same cycle as `done`.
- Minimum spacing between accepted starts is 4·SETTLE+2 cycles.
- `z` is a combinational function of `x` and `y` and needs at least one cycle to settle; it must be stable when sampled.

## Test plan
- **Correct OR:** `z`=x|y, SETTLE=2, `start` pulse at E0 → {x,y}=00,01,10,11 changing at E0,E2,E4,E6; `done` after E8; `pass`=1, `err_count`=0, `fail_vec`=0000.
- **Wrong gate:** `z`=x&y, TRUTH_TABLE=1110 → `err_count`=2, `fail_vec`=0110, `pass`=0.
- **Stuck and AND checks:**
  - `z` stuck 0 → `err_count`=3, `fail_vec`=1110.
  - TRUTH_TABLE=1000 with an AND model and SETTLE=1 → `pass`=1, `done` after E4.
- **Abort:** `z` stuck 1, `abort` at E3 → IDLE after E3, `busy`=0, no `done`, `x`=`y`=0, `fail_vec`=0001, `err_count`=1, `pass`=0. A following start with a correct OR gives `pass`=1 and counts cleared.
- **Start handling:**
  - `start` pulses at E2 and E5 during a run are ignored, and the run still ends after E8.
  - `start` held high gives back-to-back runs with `busy` low for 2 cycles (DONE, IDLE) between them.
- **Reset:** `rst_n` dropped mid-cycle during RUN → all outputs 0 immediately without a clock edge. After release, one `start` runs normally.
